// File: rtl/hub75_bcm_driver.sv
// HUB75 panel driver with binary-code-modulated bit-planes and global brightness.
// Fetches two half-panel rows per plane from a framebuffer and overlaps shifting with display.
//
// Ports:
//   sysclk, rst          clock, asynchronous active-high reset
//   enable               run request (sampled in IDLE and at frame boundary)
//   brightness           global duty, captured at each latch (255 = full)
//   rd_en/row/col/plane  framebuffer read request
//   rd_data              {B2,G2,R2,B1,G1,R1}, valid one cycle after rd_en
//   R1..B2, data_clk     panel serial data and shift clock
//   regclk_out           panel latch strobe
//   linesel_out          displayed row pair
//   output_en            panel output enable, active low
//   busy, frame_done     status
module hub75_bcm_driver #(
    parameter int COLS       = 32,
    parameter int ROW_ADDR_W = 3,
    parameter int PLANES     = 4,
    parameter int BASE_OE    = 8,
    localparam int CW        = $clog2(COLS),
    localparam int PW        = (PLANES > 1) ? $clog2(PLANES) : 1
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [7:0]            brightness,
    output logic                  rd_en,
    output logic [ROW_ADDR_W-1:0] rd_row,
    output logic [CW-1:0]         rd_col,
    output logic [PW-1:0]         rd_plane,
    input  logic [5:0]            rd_data,
    output logic                  R1,
    output logic                  G1,
    output logic                  B1,
    output logic                  R2,
    output logic                  G2,
    output logic                  B2,
    output logic                  data_clk,
    output logic                  regclk_out,
    output logic [ROW_ADDR_W-1:0] linesel_out,
    output logic                  output_en,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int TW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT,
        S_BLANK,
        S_LATCH,
        S_DRAIN
    } state_t;

    state_t state, state_n;

    logic [1:0]            ph;
    logic [CW-1:0]         col;
    logic [ROW_ADDR_W-1:0] row;
    logic [PW-1:0]         plane;
    logic [TW-1:0]         timer;
    logic [TW-1:0]         elapsed;
    logic [TW-1:0]         on_time;
    logic [TW-1:0]         on_next;
    logic [7:0]            bright_q;
    logic [5:0]            pix;
    logic                  dclk_q;
    logic [ROW_ADDR_W-1:0] line_q;

    logic last_col;
    logic last_plane;
    logic last_row;
    logic frame_end;
    logic timer_zero;
    logic [24:0] duty_lim;
    logic [24:0] elapsed_scaled;
    logic oe_on;

    assign last_col   = (col == CW'(COLS - 1));
    assign last_plane = (plane == PW'(PLANES - 1));
    assign last_row   = (row == {ROW_ADDR_W{1'b1}});
    assign frame_end  = last_row && last_plane;
    assign timer_zero = (timer == '0);
    assign on_next    = TW'(BASE_OE) << plane;

    // Lit while elapsed/on_time < (brightness+1)/256, kept exact in 25 bits.
    assign duty_lim       = 25'(on_time) * 25'({1'b0, bright_q} + 9'd1);
    assign elapsed_scaled = {1'b0, elapsed, 8'h00};
    assign oe_on          = !timer_zero && (elapsed_scaled < duty_lim);

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (enable) state_n = S_SHIFT;
            S_SHIFT: begin
                if (ph == 2'd2 && last_col)
                    state_n = timer_zero ? S_BLANK : S_WAIT;
            end
            S_WAIT:  if (timer_zero) state_n = S_BLANK;
            S_BLANK: state_n = S_LATCH;
            S_LATCH: begin
                if (frame_end && !enable) state_n = S_DRAIN;
                else                      state_n = S_SHIFT;
            end
            S_DRAIN: if (timer_zero) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ph       <= '0;
            col      <= '0;
            row      <= '0;
            plane    <= '0;
            timer    <= '0;
            elapsed  <= '0;
            on_time  <= '0;
            bright_q <= '0;
            pix      <= '0;
            dclk_q   <= 1'b0;
            line_q   <= '0;
        end else begin
            state <= state_n;

            // Shift clock trails ph2 by a cycle so data has a full cycle of setup.
            dclk_q <= (state == S_SHIFT) && (ph == 2'd2);

            if (state == S_IDLE) begin
                ph  <= '0;
                col <= '0;
            end

            if (state == S_SHIFT) begin
                if (ph == 2'd1)
                    pix <= rd_data;
                if (ph == 2'd2) begin
                    ph  <= '0;
                    col <= last_col ? '0 : col + CW'(1);
                end else begin
                    ph <= ph + 2'd1;
                end
            end

            if (state == S_BLANK)
                line_q <= row;

            if (state == S_LATCH) begin
                bright_q <= brightness;
                on_time  <= on_next;
                timer    <= on_next;
                elapsed  <= '0;
                if (last_plane) begin
                    plane <= '0;
                    row   <= row + ROW_ADDR_W'(1);
                end else begin
                    plane <= plane + PW'(1);
                end
            end else if (!timer_zero) begin
                timer   <= timer - TW'(1);
                elapsed <= elapsed + TW'(1);
            end
        end
    end

    assign rd_en       = (state == S_SHIFT) && (ph == 2'd0);
    assign rd_row      = row;
    assign rd_col      = col;
    assign rd_plane    = plane;
    assign {B2, G2, R2, B1, G1, R1} = pix;
    assign data_clk    = dclk_q;
    assign regclk_out  = (state == S_LATCH);
    assign frame_done  = (state == S_LATCH) && frame_end;
    assign linesel_out = line_q;
    assign busy        = (state != S_IDLE);

    always_comb begin
        output_en = 1'b1;
        if (state == S_SHIFT || state == S_WAIT || state == S_DRAIN)
            output_en = !oe_on;
    end

endmodule
